// File: rtl/bp_be_pkg.sv
// Shared types for the back-end to front-end command issuer: configuration,
// front-end command format, issuer FSM states and opcode helpers.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int vaddr_width_gp               = 39;
    localparam int branch_metadata_fwd_width_gp = 16;

    function automatic int cfg_vaddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return vaddr_width_gp;
            default:          return vaddr_width_gp;
        endcase
    endfunction

    typedef enum logic [2:0] {
        e_op_state_reset          = 3'd0,
        e_op_pc_redirection       = 3'd1,
        e_op_icache_fill_response = 3'd2,
        e_op_branch_update        = 3'd3,
        e_op_attaboy              = 3'd4,
        e_op_icache_fence         = 3'd5,
        e_op_itlb_fill_response   = 3'd6,
        e_op_itlb_fence           = 3'd7
    } bp_fe_cmd_op_e;

    typedef enum logic [1:0] {
        e_priv_user       = 2'd0,
        e_priv_supervisor = 2'd1,
        e_priv_machine    = 2'd3
    } bp_priv_e;

    typedef struct packed {
        bp_fe_cmd_op_e                          opcode;
        logic [vaddr_width_gp-1:0]              npc;
        bp_priv_e                               priv;
        logic                                   translation_en;
        logic [branch_metadata_fwd_width_gp-1:0] branch_metadata_fwd;
    } bp_fe_cmd_s;

    localparam int fe_cmd_width_gp = $bits(bp_fe_cmd_s);

    typedef enum logic [1:0] {
        e_boot  = 2'd0,
        e_run   = 2'd1,
        e_fence = 2'd2
    } bp_be_issuer_state_e;

    // Which source the registered fe_cmd currently reflects; decides what a yumi pops.
    typedef enum logic [1:0] {
        e_src_none    = 2'd0,
        e_src_boot    = 2'd1,
        e_src_queue   = 2'd2,
        e_src_attaboy = 2'd3
    } bp_be_issuer_src_e;

    function automatic logic is_fence_op(bp_fe_cmd_op_e op);
        return (op == e_op_icache_fence) || (op == e_op_itlb_fence);
    endfunction

endpackage

// File: rtl/bp_be_fe_cmd_issuer_if.sv
// Command request, attaboy and front-end command handshakes of the issuer.
interface bp_be_fe_cmd_issuer_if;
    import bp_be_pkg::*;

    logic       cmd_v_i;
    bp_fe_cmd_s cmd_i;
    logic       cmd_ready_o;
    logic       attaboy_v_i;
    bp_fe_cmd_s attaboy_i;
    bp_fe_cmd_s fe_cmd_o;
    logic       fe_cmd_v_o;
    logic       fe_cmd_yumi_i;

    modport slave (
        input  cmd_v_i, cmd_i, attaboy_v_i, attaboy_i, fe_cmd_yumi_i,
        output cmd_ready_o, fe_cmd_o, fe_cmd_v_o
    );

    modport master (
        output cmd_v_i, cmd_i, attaboy_v_i, attaboy_i, fe_cmd_yumi_i,
        input  cmd_ready_o, fe_cmd_o, fe_cmd_v_o
    );
endinterface

// File: rtl/bp_be_fe_cmd_queue.sv
// Two-entry FIFO for pending commands; exposes next-cycle head/empty so the
// issuer can register its output without a path from the request inputs.
module bp_be_fe_cmd_queue #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_v_i,
    input  logic [width_p-1:0] enq_data_i,
    input  logic               deq_i,
    output logic               full_o,
    output logic               empty_n_o,
    output logic [width_p-1:0] head_n_o
);
    logic [1:0]         wptr_r, rptr_r, wptr_n, rptr_n;
    logic [width_p-1:0] mem_r [2];

    assign wptr_n    = wptr_r + 2'(enq_v_i);
    assign rptr_n    = rptr_r + 2'(deq_i);
    assign full_o    = (wptr_r[0] == rptr_r[0]) && (wptr_r[1] != rptr_r[1]);
    assign empty_n_o = (wptr_n == rptr_n);
    // The slot being written becomes the head when the queue drains into it.
    assign head_n_o  = (enq_v_i && (wptr_r[0] == rptr_n[0])) ? enq_data_i : mem_r[rptr_n[0]];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_v_i) mem_r[wptr_r[0]] <= enq_data_i;
    end
endmodule

// File: rtl/bp_be_fe_cmd_issuer.sv
// Issues boot, queued and attaboy commands to the front end through a fully
// registered fe_cmd port.
//   state   | meaning
//   e_boot  | presenting the state-reset command until the front end takes it
//   e_run   | accepting requests, issuing queue head or buffered attaboy
//   e_fence | fence popped; nothing issued until fence_done_i
module bp_be_fe_cmd_issuer import bp_be_pkg::*; #(
    parameter bp_params_e bp_params_p      = e_bp_default_cfg,
    parameter int         drop_cnt_width_p = 8,
    localparam int        vaddr_width_p    = cfg_vaddr_width(bp_params_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [vaddr_width_p-1:0]    boot_pc_i,
    input  logic                        fence_done_i,
    bp_be_fe_cmd_issuer_if.slave        bus,
    output logic [drop_cnt_width_p-1:0] attaboy_drop_cnt_o
);
    bp_be_issuer_state_e state_r, state_n;
    bp_be_issuer_src_e   src_r, src_n;
    bp_fe_cmd_s          fe_cmd_r, fe_cmd_n, ab_r, ab_n, head_n;
    logic                fe_cmd_v_r, fe_cmd_v_n, ab_v_r, ab_v_n, drop;
    logic [drop_cnt_width_p-1:0] drop_cnt_r, drop_cnt_n;
    logic                q_full, q_empty_n, enq, deq, ab_pop, boot_pop, redirect_enq;
    logic [fe_cmd_width_gp-1:0] head_n_raw;

    assign bus.cmd_ready_o    = (state_r == e_run) && !q_full;
    assign bus.fe_cmd_o       = fe_cmd_r;
    assign bus.fe_cmd_v_o     = fe_cmd_v_r;
    assign attaboy_drop_cnt_o = drop_cnt_r;

    assign enq          = bus.cmd_v_i && bus.cmd_ready_o;
    assign deq          = bus.fe_cmd_yumi_i && (src_r == e_src_queue);
    assign ab_pop       = bus.fe_cmd_yumi_i && (src_r == e_src_attaboy);
    assign boot_pop     = bus.fe_cmd_yumi_i && (src_r == e_src_boot);
    assign redirect_enq = enq && (bus.cmd_i.opcode == e_op_pc_redirection);
    assign head_n       = bp_fe_cmd_s'(head_n_raw);

    bp_be_fe_cmd_queue #(.width_p(fe_cmd_width_gp)) queue (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .enq_v_i    (enq),
        .enq_data_i (bus.cmd_i),
        .deq_i      (deq),
        .full_o     (q_full),
        .empty_n_o  (q_empty_n),
        .head_n_o   (head_n_raw)
    );

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_boot:  if (boot_pop) state_n = e_run;
            e_run:   if (deq && is_fence_op(fe_cmd_r.opcode)) state_n = e_fence;
            e_fence: if (fence_done_i) state_n = e_run;
            default: state_n = e_boot;
        endcase
    end

    // A redirect makes any speculative attaboy stale, including one arriving alongside it.
    always_comb begin
        ab_v_n = ab_v_r;
        ab_n   = ab_r;
        drop   = 1'b0;
        if (redirect_enq) begin
            ab_v_n = 1'b0;
            drop   = bus.attaboy_v_i;
        end else if (bus.attaboy_v_i) begin
            ab_v_n = 1'b1;
            ab_n   = bus.attaboy_i;
            drop   = ab_v_r && !ab_pop;
        end else if (ab_pop) begin
            ab_v_n = 1'b0;
        end
        drop_cnt_n = (drop && !(&drop_cnt_r)) ? drop_cnt_r + drop_cnt_width_p'(1) : drop_cnt_r;
    end

    always_comb begin
        fe_cmd_n   = '0;
        fe_cmd_v_n = 1'b0;
        src_n      = e_src_none;
        if (state_n == e_boot) begin
            fe_cmd_n.opcode         = e_op_state_reset;
            fe_cmd_n.npc            = boot_pc_i;
            fe_cmd_n.priv           = e_priv_machine;
            fe_cmd_n.translation_en = 1'b0;
            fe_cmd_v_n              = 1'b1;
            src_n                   = e_src_boot;
        end else if (state_n == e_run) begin
            if (!q_empty_n) begin
                fe_cmd_n   = head_n;
                fe_cmd_v_n = 1'b1;
                src_n      = e_src_queue;
            end else if (ab_v_n) begin
                fe_cmd_n   = ab_n;
                fe_cmd_v_n = 1'b1;
                src_n      = e_src_attaboy;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_boot;
            src_r      <= e_src_none;
            fe_cmd_r   <= '0;
            fe_cmd_v_r <= 1'b0;
            ab_r       <= '0;
            ab_v_r     <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            state_r    <= state_n;
            src_r      <= src_n;
            fe_cmd_r   <= fe_cmd_n;
            fe_cmd_v_r <= fe_cmd_v_n;
            ab_r       <= ab_n;
            ab_v_r     <= ab_v_n;
            drop_cnt_r <= drop_cnt_n;
        end
    end
endmodule

// File: tb/tb_bp_be_fe_cmd_issuer.sv
// Directed bench for the fe command issuer: vector table plus reset,
// saturation and asynchronous-reset sequences.
module tb_bp_be_fe_cmd_issuer;
    import bp_be_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [38:0] boot_pc_i;
    logic        fence_done_i;
    logic [7:0]  drop_cnt;

    bp_be_fe_cmd_issuer_if bus();

    bp_be_fe_cmd_issuer #(.bp_params_p(e_bp_default_cfg), .drop_cnt_width_p(8)) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .boot_pc_i          (boot_pc_i),
        .fence_done_i       (fence_done_i),
        .bus                (bus),
        .attaboy_drop_cnt_o (drop_cnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          cv;
        bp_fe_cmd_op_e cop;
        logic [38:0]   cpc;
        logic          av;
        logic [38:0]   apc;
        logic          y;
        logic          fd;
        logic          ev;
        bp_fe_cmd_op_e eop;
        logic [38:0]   epc;
        logic          erdy;
        logic [7:0]    ecnt;
    } vec_t;

    localparam bp_fe_cmd_op_e SR = e_op_state_reset;
    localparam bp_fe_cmd_op_e RD = e_op_pc_redirection;
    localparam bp_fe_cmd_op_e AB = e_op_attaboy;
    localparam bp_fe_cmd_op_e BU = e_op_branch_update;
    localparam bp_fe_cmd_op_e IF = e_op_icache_fence;
    localparam bp_fe_cmd_op_e TF = e_op_itlb_fence;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bp_fe_cmd_s mkcmd(bp_fe_cmd_op_e op, logic [38:0] pc);
        bp_fe_cmd_s c;
        c        = '0;
        c.opcode = op;
        c.npc    = pc;
        return c;
    endfunction

    function automatic vec_t mkv(logic cv, bp_fe_cmd_op_e cop, logic [38:0] cpc,
                                 logic av, logic [38:0] apc, logic y, logic fd,
                                 logic ev, bp_fe_cmd_op_e eop, logic [38:0] epc,
                                 logic erdy, logic [7:0] ecnt);
        vec_t v;
        v.cv = cv; v.cop = cop; v.cpc = cpc; v.av = av; v.apc = apc; v.y = y; v.fd = fd;
        v.ev = ev; v.eop = eop; v.epc = epc; v.erdy = erdy; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic idle();
        bus.cmd_v_i       = 1'b0;
        bus.cmd_i         = mkcmd(RD, '0);
        bus.attaboy_v_i   = 1'b0;
        bus.attaboy_i     = mkcmd(AB, '0);
        bus.fe_cmd_yumi_i = 1'b0;
        fence_done_i      = 1'b0;
    endtask

    initial begin
        //                cv cop  cpc      av apc      y  fd   ev eop  epc      rdy cnt
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   1, 0)); // boot taken
        vecs.push_back(mkv(1, RD, 39'h100, 0, 39'h0,   0, 0,   1, RD, 39'h100, 1, 0)); // A
        vecs.push_back(mkv(1, RD, 39'h200, 0, 39'h0,   0, 0,   1, RD, 39'h100, 0, 0)); // B -> full
        vecs.push_back(mkv(1, RD, 39'h300, 0, 39'h0,   0, 0,   1, RD, 39'h100, 0, 0)); // C held off
        vecs.push_back(mkv(1, RD, 39'h300, 0, 39'h0,   1, 0,   1, RD, 39'h200, 1, 0)); // pop A, no bypass
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   1, 0)); // pop B
        vecs.push_back(mkv(0, RD, 39'h0,   1, 39'h400, 0, 0,   1, AB, 39'h400, 1, 0)); // X
        vecs.push_back(mkv(0, RD, 39'h0,   1, 39'h500, 0, 0,   1, AB, 39'h500, 1, 1)); // Y replaces X
        vecs.push_back(mkv(1, RD, 39'h600, 0, 39'h0,   0, 0,   1, RD, 39'h600, 1, 1)); // R clears Y
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   1, 1));
        vecs.push_back(mkv(1, RD, 39'h700, 1, 39'h800, 0, 0,   1, RD, 39'h700, 1, 2)); // redirect + attaboy
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   1, 2));
        vecs.push_back(mkv(1, RD, 39'h900, 0, 39'h0,   0, 0,   1, RD, 39'h900, 1, 2)); // D
        vecs.push_back(mkv(1, RD, 39'hA00, 0, 39'h0,   1, 0,   1, RD, 39'hA00, 1, 2)); // E in, D out
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   1, 2));
        vecs.push_back(mkv(0, RD, 39'h0,   1, 39'hB00, 0, 0,   1, AB, 39'hB00, 1, 2)); // W
        vecs.push_back(mkv(0, RD, 39'h0,   1, 39'hC00, 1, 0,   1, AB, 39'hC00, 1, 2)); // W popped, V kept
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   1, 2));
        vecs.push_back(mkv(1, IF, 39'hD00, 0, 39'h0,   0, 0,   1, IF, 39'hD00, 1, 2)); // icache fence
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   0, 2)); // -> e_fence
        vecs.push_back(mkv(0, RD, 39'h0,   1, 39'hE00, 0, 0,   0, SR, 39'h0,   0, 2)); // T buffered
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   0, 0,   0, SR, 39'h0,   0, 2));
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   0, 1,   1, AB, 39'hE00, 1, 2)); // fence done
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   1, 2));
        vecs.push_back(mkv(0, RD, 39'h0,   1, 39'hF00, 0, 0,   1, AB, 39'hF00, 1, 2)); // U
        vecs.push_back(mkv(1, BU, 39'h1100,0, 39'h0,   0, 0,   1, BU, 39'h1100,1, 2)); // queue wins
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   1, AB, 39'hF00, 1, 2)); // U survives
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   1, 2));
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   0, 1,   0, SR, 39'h0,   1, 2)); // stray fence_done
        vecs.push_back(mkv(1, TF, 39'h1200,0, 39'h0,   0, 0,   1, TF, 39'h1200,1, 2)); // itlb fence
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   1, 0,   0, SR, 39'h0,   0, 2));
        vecs.push_back(mkv(0, RD, 39'h0,   0, 39'h0,   0, 1,   0, SR, 39'h0,   1, 2));

        idle();
        reset_n_i = 1'b0;
        boot_pc_i = 39'h8000_0000;
        #12;
        chk("reset.valid", bus.fe_cmd_v_o, 0);
        chk("reset.ready", bus.cmd_ready_o, 0);
        chk("reset.drop_cnt", drop_cnt, 0);

        @(negedge clk_i) reset_n_i = 1'b1;
        @(posedge clk_i) #1;
        chk("boot.valid", bus.fe_cmd_v_o, 1);
        chk("boot.opcode", bus.fe_cmd_o.opcode, SR);
        chk("boot.npc", bus.fe_cmd_o.npc, 39'h8000_0000);
        chk("boot.priv", bus.fe_cmd_o.priv, 2'd3);
        chk("boot.translation_en", bus.fe_cmd_o.translation_en, 0);
        chk("boot.ready", bus.cmd_ready_o, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            bus.cmd_v_i       = vecs[i].cv;
            bus.cmd_i         = mkcmd(vecs[i].cop, vecs[i].cpc);
            bus.attaboy_v_i   = vecs[i].av;
            bus.attaboy_i     = mkcmd(AB, vecs[i].apc);
            bus.fe_cmd_yumi_i = vecs[i].y;
            fence_done_i      = vecs[i].fd;
            @(posedge clk_i) #1;
            chk($sformatf("v%0d.valid", i), bus.fe_cmd_v_o, vecs[i].ev);
            chk($sformatf("v%0d.ready", i), bus.cmd_ready_o, vecs[i].erdy);
            chk($sformatf("v%0d.drop_cnt", i), drop_cnt, vecs[i].ecnt);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d.opcode", i), bus.fe_cmd_o.opcode, vecs[i].eop);
                chk($sformatf("v%0d.npc", i), bus.fe_cmd_o.npc, vecs[i].epc);
            end
        end

        // 300 overwriting attaboys: first fills the empty buffer, rest each drop one.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            idle();
            bus.attaboy_v_i = 1'b1;
            bus.attaboy_i   = mkcmd(AB, 39'(k));
        end
        @(negedge clk_i);
        idle();
        chk("sat.drop_cnt", drop_cnt, 8'd255);
        chk("sat.valid", bus.fe_cmd_v_o, 1);
        chk("sat.npc", bus.fe_cmd_o.npc, 39'd299);
        bus.fe_cmd_yumi_i = 1'b1;
        @(negedge clk_i);
        idle();
        chk("sat.cleared", bus.fe_cmd_v_o, 0);

        // Two queued commands, then reset in the middle of a cycle.
        bus.cmd_v_i = 1'b1;
        bus.cmd_i   = mkcmd(RD, 39'h1300);
        @(negedge clk_i);
        bus.cmd_i   = mkcmd(RD, 39'h1400);
        @(negedge clk_i);
        idle();
        chk("prereset.valid", bus.fe_cmd_v_o, 1);
        chk("prereset.ready", bus.cmd_ready_o, 0);
        #2 reset_n_i = 1'b0;
        #1;
        chk("async_reset.valid", bus.fe_cmd_v_o, 0);
        chk("async_reset.ready", bus.cmd_ready_o, 0);
        chk("async_reset.drop_cnt", drop_cnt, 0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i) #1;
        chk("reboot.valid", bus.fe_cmd_v_o, 1);
        chk("reboot.opcode", bus.fe_cmd_o.opcode, SR);
        chk("reboot.npc", bus.fe_cmd_o.npc, 39'h8000_0000);
        @(negedge clk_i) bus.fe_cmd_yumi_i = 1'b1;
        @(posedge clk_i) #1;
        chk("reboot.queue_lost", bus.fe_cmd_v_o, 0);
        chk("reboot.ready", bus.cmd_ready_o, 1);
        @(negedge clk_i) idle();
        @(posedge clk_i) #1;
        chk("reboot.idle", bus.fe_cmd_v_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
